// File: rtl/keypad_scan4_if.sv
// Keypad pin and key-report bundle for keypad_scan4.
// Digit outputs d0..d3 exist only when KEYPAD_DIGIT_SHIFT_EN is defined.
interface keypad_scan4_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
`ifdef KEYPAD_DIGIT_SHIFT_EN
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;

    modport master (
        input  col_n,
        output row_n, key_code, key_valid, key_held, d0, d1, d2, d3
    );
    modport slave (
        output col_n,
        input  row_n, key_code, key_valid, key_held, d0, d1, d2, d3
    );
`else
    modport master (
        input  col_n,
        output row_n, key_code, key_valid, key_held
    );
    modport slave (
        output col_n,
        input  row_n, key_code, key_valid, key_held
    );
`endif
endinterface

// File: rtl/keypad_scan4.sv
// 4x4 matrix keypad scanner with frame debounce and hex key reporting.
// Optional digit shift register enabled by KEYPAD_DIGIT_SHIFT_EN.
module keypad_scan4 #(
    parameter int unsigned TICK_DIV        = 200000,
    parameter int unsigned DEBOUNCE_FRAMES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_scan4_if.master bus
);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] CNT_MAX    = DW'(DEBOUNCE_FRAMES - 1);
    localparam logic [DW-1:0] CNT_STABLE = DW'(DEBOUNCE_FRAMES - 2);

    typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_t;

    row_t          row_q, row_d;
    logic [3:0]    row_drive;
    logic [3:0]    sync1, sync2;
    logic [CW-1:0] tick_cnt;
    logic          tick, frame_end;
    logic [1:0]    acc_cnt, frame_cnt;
    logic [3:0]    acc_code, frame_code;
    logic [4:0]    frame_res, last_res;
    logic [DW-1:0] db_cnt;
    logic          same, stable;
    logic [3:0]    code_q;
    logic          valid_q, held_q;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: keymap = 4'h1;  4'h1: keymap = 4'h2;  4'h2: keymap = 4'h3;  4'h3: keymap = 4'hA;
            4'h4: keymap = 4'h4;  4'h5: keymap = 4'h5;  4'h6: keymap = 4'h6;  4'h7: keymap = 4'hB;
            4'h8: keymap = 4'h7;  4'h9: keymap = 4'h8;  4'hA: keymap = 4'h9;  4'hB: keymap = 4'hC;
            4'hC: keymap = 4'hE;  4'hD: keymap = 4'h0;  4'hE: keymap = 4'hF;  4'hF: keymap = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.col_n;
            sync2 <= sync1;
        end
    end

    assign tick      = (tick_cnt == TICK_LAST);
    assign frame_end = tick && (row_q == ROW3);

    always_ff @(posedge clk) begin
        if (!rst_n) tick_cnt <= '0;
        else        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
    end

    // Row scan FSM: state register, next-state, Moore row drive.
    always_ff @(posedge clk) begin
        if (!rst_n) row_q <= ROW0;
        else        row_q <= row_d;
    end

    always_comb begin
        row_d = row_q;
        if (tick) begin
            case (row_q)
                ROW0: row_d = ROW1;
                ROW1: row_d = ROW2;
                ROW2: row_d = ROW3;
                ROW3: row_d = ROW0;
            endcase
        end
    end

    always_comb begin
        row_drive = '1;
        case (row_q)
            ROW0: row_drive = 4'b1110;
            ROW1: row_drive = 4'b1101;
            ROW2: row_drive = 4'b1011;
            ROW3: row_drive = 4'b0111;
        endcase
    end

    // Pressed-cell count saturates at 2; anything but exactly one is NONE.
    always_comb begin
        frame_cnt  = (row_q == ROW0) ? 2'd0 : acc_cnt;
        frame_code = (row_q == ROW0) ? 4'h0 : acc_code;
        for (int unsigned c = 0; c < 4; c++) begin
            if (!sync2[c]) begin
                if (frame_cnt != 2'd2) frame_cnt = frame_cnt + 2'd1;
                frame_code = keymap(row_q, c[1:0]);
            end
        end
    end

    assign frame_res = (frame_cnt == 2'd1) ? {1'b1, frame_code} : 5'h00;
    assign same      = (frame_res == last_res);
    assign stable    = same && (db_cnt == CNT_STABLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            acc_code <= '0;
            last_res <= '0;
            db_cnt   <= '0;
        end else if (tick) begin
            acc_cnt  <= frame_cnt;
            acc_code <= frame_code;
            if (row_q == ROW3) begin
                if (same) begin
                    if (db_cnt != CNT_MAX) db_cnt <= db_cnt + DW'(1);
                end else begin
                    db_cnt   <= '0;
                    last_res <= frame_res;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (frame_end && stable) begin
                if (frame_res[4] && !held_q) begin
                    code_q  <= frame_res[3:0];
                    held_q  <= 1'b1;
                    valid_q <= 1'b1;
                end else if (!frame_res[4]) begin
                    held_q <= 1'b0;
                end
            end
        end
    end

    assign bus.row_n     = row_drive;
    assign bus.key_code  = code_q;
    assign bus.key_valid = valid_q;
    assign bus.key_held  = held_q;

`ifdef KEYPAD_DIGIT_SHIFT_EN
    logic [3:0] d0_q, d1_q, d2_q, d3_q;

    always_ff @(posedge clk) begin
        if (!rst_n || (valid_q && code_q == 4'hE)) begin
            d0_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
        end else if (valid_q) begin
            d3_q <= d2_q;
            d2_q <= d1_q;
            d1_q <= d0_q;
            d0_q <= code_q;
        end
    end

    assign bus.d0 = d0_q;
    assign bus.d1 = d1_q;
    assign bus.d2 = d2_q;
    assign bus.d3 = d3_q;
`endif
endmodule
